sakiz_otomati: RTL and testbench

Parametrised multi-product vending controller, successor to the single-product `sakiz` block. Accepts three coin types, accumulates credit, vends one of `N_PROD` products at per-product prices with a ready/valid handshake to the dispenser, and returns change or refunds one coin per cycle. Sits between the coin acceptor front-end and the product dispenser.

---
 rtl/sakiz_pkg.sv | 24 ++
 rtl/sakiz_otomati_para_ustu.sv | 29 ++
 rtl/sakiz_otomati.sv | 202 ++++++++++++++++++++
 tb/tb_sakiz_otomati.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sakiz_pkg.sv
// Shared types and helpers for the multi-product vending controller.
// Holds the FSM state encoding, default coin values and price-table slicing.
package sakiz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_t;

  localparam int DEF_COIN_A = 5;
  localparam int DEF_COIN_B = 10;
  localparam int DEF_COIN_C = 25;

  // Price tables are widened to this many bits before slicing (16 products x 32 bits).
  localparam int PRICE_TBL_W = 512;

  function automatic logic [31:0] price_slice(input logic [PRICE_TBL_W-1:0] tbl,
                                              input int unsigned w,
                                              input int unsigned idx);
    return 32'(tbl >> (idx * w)) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/sakiz_otomati_para_ustu.sv
// Greedy change selector: picks the largest coin not exceeding the credit.
// Purely combinational, zero latency, no flow control.
module para_ustu
  import sakiz_pkg::*;
#(
  parameter int CREDIT_W = 8,
  parameter int COIN_A   = DEF_COIN_A,
  parameter int COIN_B   = DEF_COIN_B,
  parameter int COIN_C   = DEF_COIN_C
) (
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [2:0]          o_coin_oh,
  output logic [CREDIT_W-1:0] o_dec
);

  // One-hot order is {C, B, A}; a zero credit still yields coin A, callers gate it.
  always_comb begin
    o_coin_oh = 3'b001;
    o_dec     = CREDIT_W'(COIN_A);
    if (i_credit >= CREDIT_W'(COIN_C)) begin
      o_coin_oh = 3'b100;
      o_dec     = CREDIT_W'(COIN_C);
    end else if (i_credit >= CREDIT_W'(COIN_B)) begin
      o_coin_oh = 3'b010;
      o_dec     = CREDIT_W'(COIN_B);
    end
  end

endmodule

// File: rtl/sakiz_otomati.sv
// Multi-product vending FSM: credit accumulation, vend handshake, greedy change.
// All outputs registered (1 cycle); vend_valid holds until vend_ready, coins rejected while busy.
module sakiz_otomati
  import sakiz_pkg::*;
#(
  parameter int                        N_PROD     = 4,
  parameter int                        CREDIT_W   = 8,
  parameter int                        COIN_A     = DEF_COIN_A,
  parameter int                        COIN_B     = DEF_COIN_B,
  parameter int                        COIN_C     = DEF_COIN_C,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES    = {8'd100, 8'd55, 8'd40, 8'd25},
  parameter int                        MAX_CREDIT = 100,
  localparam int                       ID_W       = $clog2(N_PROD)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                A_in,
  input  logic                B_in,
  input  logic                C_in,
  input  logic                sel_valid,
  input  logic [ID_W-1:0]     sel_id,
  input  logic                cancel,
  output logic                vend_valid,
  output logic [ID_W-1:0]     vend_id,
  input  logic                vend_ready,
  output logic                A_out,
  output logic                B_out,
  output logic                C_out,
  output logic                coin_rej,
  output logic                no_credit,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  if (N_PROD < 2 || N_PROD > 16) begin : g_bad_nprod
    $error("N_PROD must be within 2..16");
  end
  if (CREDIT_W > 32) begin : g_bad_width
    $error("CREDIT_W must not exceed 32");
  end
  if (MAX_CREDIT + COIN_C >= (64'd1 << CREDIT_W)) begin : g_bad_ceiling
    $error("MAX_CREDIT + COIN_C does not fit in CREDIT_W");
  end
  if ((COIN_B % COIN_A) != 0 || (COIN_C % COIN_A) != 0 || (MAX_CREDIT % COIN_A) != 0) begin : g_bad_coin
    $error("coin values and MAX_CREDIT must be multiples of COIN_A");
  end
  for (genvar g = 0; g < N_PROD; g++) begin : g_chk_price
    if ((PRICES[g*CREDIT_W +: CREDIT_W] % COIN_A) != 0) begin : g_bad_price
      $error("every price must be a multiple of COIN_A");
    end
  end

  localparam logic [PRICE_TBL_W-1:0] L_TBL = PRICE_TBL_W'(PRICES);
  localparam logic [CREDIT_W-1:0]    L_A   = CREDIT_W'(COIN_A);
  localparam logic [CREDIT_W-1:0]    L_B   = CREDIT_W'(COIN_B);
  localparam logic [CREDIT_W-1:0]    L_C   = CREDIT_W'(COIN_C);
  localparam logic [CREDIT_W-1:0]    L_MAX = CREDIT_W'(MAX_CREDIT);

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_vend_valid;
  logic [ID_W-1:0]     r_vend_id;
  logic [2:0]          r_coins;
  logic                r_coin_rej;
  logic                r_no_credit;
  logic                r_busy;

  state_t              w_nxt_state;
  logic [CREDIT_W-1:0] w_nxt_credit;
  logic                w_nxt_vend_valid;
  logic [ID_W-1:0]     w_nxt_vend_id;
  logic [2:0]          w_nxt_coins;
  logic                w_nxt_rej;
  logic                w_nxt_noc;

  logic [CREDIT_W-1:0] w_sel_price;
  logic [CREDIT_W-1:0] w_vend_price;
  logic [CREDIT_W-1:0] w_rem;
  logic [CREDIT_W-1:0] w_coin_val;
  logic [CREDIT_W-1:0] w_coin_sum;
  logic [CREDIT_W-1:0] w_chg_in;
  logic [CREDIT_W-1:0] w_chg_dec;
  logic [2:0]          w_chg_oh;
  logic                w_coin_any;
  logic                w_coin_ok;
  logic                w_sel_ok;
  logic                w_cancel_go;

  assign w_sel_price  = CREDIT_W'(price_slice(L_TBL, CREDIT_W, 32'(sel_id)));
  assign w_vend_price = CREDIT_W'(price_slice(L_TBL, CREDIT_W, 32'(r_vend_id)));
  assign w_rem        = r_credit - w_vend_price;

  assign w_coin_any = A_in | B_in | C_in;
  assign w_coin_val = A_in ? L_A : (B_in ? L_B : L_C);
  assign w_coin_sum = r_credit + w_coin_val;
  assign w_coin_ok  = !((A_in & B_in) | (A_in & C_in) | (B_in & C_in)) && (w_coin_sum <= L_MAX);

  assign w_sel_ok    = (32'(sel_id) < 32'(N_PROD)) && (r_credit >= w_sel_price);
  assign w_cancel_go = cancel && (r_credit != '0);

  // The handshake cycle already issues the first change coin, so feed it the post-price remainder.
  assign w_chg_in = (r_state == ST_VEND) ? w_rem : r_credit;

  para_ustu #(
    .CREDIT_W (CREDIT_W),
    .COIN_A   (COIN_A),
    .COIN_B   (COIN_B),
    .COIN_C   (COIN_C)
  ) u_para_ustu (
    .i_credit  (w_chg_in),
    .o_coin_oh (w_chg_oh),
    .o_dec     (w_chg_dec)
  );

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_credit     = r_credit;
    w_nxt_vend_valid = r_vend_valid;
    w_nxt_vend_id    = r_vend_id;
    w_nxt_coins      = 3'b000;
    w_nxt_rej        = 1'b0;
    w_nxt_noc        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cancel_go) begin
          w_nxt_coins  = w_chg_oh;
          w_nxt_credit = r_credit - w_chg_dec;
          w_nxt_state  = ST_CHANGE;
          w_nxt_rej    = w_coin_any;
        end else if (sel_valid && w_sel_ok) begin
          w_nxt_vend_valid = 1'b1;
          w_nxt_vend_id    = sel_id;
          w_nxt_state      = ST_VEND;
          w_nxt_rej        = w_coin_any;
        end else begin
          w_nxt_noc = sel_valid;
          if (w_coin_any) begin
            if (w_coin_ok) w_nxt_credit = w_coin_sum;
            else           w_nxt_rej    = 1'b1;
          end
        end
      end
      ST_VEND: begin
        w_nxt_rej = w_coin_any;
        if (vend_ready) begin
          w_nxt_vend_valid = 1'b0;
          if (w_rem != '0) begin
            w_nxt_coins  = w_chg_oh;
            w_nxt_credit = w_rem - w_chg_dec;
            w_nxt_state  = ST_CHANGE;
          end else begin
            w_nxt_credit = '0;
            w_nxt_state  = ST_IDLE;
          end
        end
      end
      ST_CHANGE: begin
        w_nxt_rej = w_coin_any;
        if (r_credit == '0) begin
          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_coins  = w_chg_oh;
          w_nxt_credit = r_credit - w_chg_dec;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_credit     <= '0;
      r_vend_valid <= 1'b0;
      r_vend_id    <= '0;
      r_coins      <= 3'b000;
      r_coin_rej   <= 1'b0;
      r_no_credit  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_credit     <= w_nxt_credit;
      r_vend_valid <= w_nxt_vend_valid;
      r_vend_id    <= w_nxt_vend_id;
      r_coins      <= w_nxt_coins;
      r_coin_rej   <= w_nxt_rej;
      r_no_credit  <= w_nxt_noc;
      r_busy       <= (w_nxt_state != ST_IDLE);
    end
  end

  assign vend_valid = r_vend_valid;
  assign vend_id    = r_vend_id;
  assign A_out      = r_coins[0];
  assign B_out      = r_coins[1];
  assign C_out      = r_coins[2];
  assign coin_rej   = r_coin_rej;
  assign no_credit  = r_no_credit;
  assign credit     = r_credit;
  assign busy       = r_busy;

endmodule

// File: tb/tb_sakiz_otomati.sv
// Directed bench for sakiz_otomati with hand-computed expectations.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_sakiz_otomati;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       A_in = 1'b0, B_in = 1'b0, C_in = 1'b0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id = 2'd0;
  logic       cancel = 1'b0;
  logic       vend_ready = 1'b0;
  logic       vend_valid;
  logic [1:0] vend_id;
  logic       A_out, B_out, C_out, coin_rej, no_credit, busy;
  logic [7:0] credit;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sakiz_otomati dut (
    .clk        (clk),
    .rst        (rst),
    .A_in       (A_in),
    .B_in       (B_in),
    .C_in       (C_in),
    .sel_valid  (sel_valid),
    .sel_id     (sel_id),
    .cancel     (cancel),
    .vend_valid (vend_valid),
    .vend_id    (vend_id),
    .vend_ready (vend_ready),
    .A_out      (A_out),
    .B_out      (B_out),
    .C_out      (C_out),
    .coin_rej   (coin_rej),
    .no_credit  (no_credit),
    .credit     (credit),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_coin(input logic a, input logic b, input logic c);
    A_in = a; B_in = b; C_in = c;
    tick();
    A_in = 1'b0; B_in = 1'b0; C_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({vend_valid, A_out, B_out, C_out, coin_rej, no_credit, busy} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {vend_valid, A_out, B_out, C_out, coin_rej, no_credit, busy});
    end
    n_cmp++;
    if (credit !== 8'd0) begin n_err++; $display("FAIL reset_credit: got %0d want 0", credit); end
  endtask

  task automatic test_coins();
    add_coin(1, 0, 0);
    n_cmp++;
    if (credit !== 8'd5) begin n_err++; $display("FAIL coin_a_credit: got %0d want 5", credit); end
    add_coin(0, 1, 0);
    n_cmp++;
    if (credit !== 8'd15) begin n_err++; $display("FAIL coin_b_credit: got %0d want 15", credit); end
    add_coin(0, 0, 1);
    n_cmp++;
    if (credit !== 8'd40) begin n_err++; $display("FAIL coin_c_credit: got %0d want 40", credit); end
    n_cmp++;
    if (busy !== 1'b0 || coin_rej !== 1'b0) begin
      n_err++; $display("FAIL coin_busy_rej: got busy=%b rej=%b want 0 0", busy, coin_rej);
    end
  endtask

  task automatic test_vend_delayed();
    sel_valid = 1'b1; sel_id = 2'd1;
    tick();
    sel_valid = 1'b0;
    n_cmp++;
    if (vend_valid !== 1'b1 || vend_id !== 2'd1 || busy !== 1'b1) begin
      n_err++; $display("FAIL vend_start: got valid=%b id=%0d busy=%b want 1 1 1", vend_valid, vend_id, busy);
    end
    add_coin(1, 0, 0);
    n_cmp++;
    if (coin_rej !== 1'b1 || credit !== 8'd40) begin
      n_err++; $display("FAIL vend_coin_rej: got rej=%b credit=%0d want 1 40", coin_rej, credit);
    end
    n_cmp++;
    if (vend_valid !== 1'b1) begin n_err++; $display("FAIL vend_hold2: got %b want 1", vend_valid); end
    tick();
    n_cmp++;
    if (vend_valid !== 1'b1 || coin_rej !== 1'b0) begin
      n_err++; $display("FAIL vend_hold3: got valid=%b rej=%b want 1 0", vend_valid, coin_rej);
    end
    tick();
    n_cmp++;
    if (vend_valid !== 1'b1 || vend_id !== 2'd1) begin
      n_err++; $display("FAIL vend_hold4: got valid=%b id=%0d want 1 1", vend_valid, vend_id);
    end
    vend_ready = 1'b1;
    tick();
    vend_ready = 1'b0;
    n_cmp++;
    if (vend_valid !== 1'b0 || credit !== 8'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL vend_done: got valid=%b credit=%0d busy=%b want 0 0 0", vend_valid, credit, busy);
    end
    n_cmp++;
    if ({A_out, B_out, C_out} !== 3'b000) begin
      n_err++; $display("FAIL vend_no_change: got %b want 000", {A_out, B_out, C_out});
    end
  endtask

  task automatic test_change();
    add_coin(0, 0, 1);
    add_coin(0, 0, 1);
    add_coin(0, 0, 1);
    add_coin(0, 0, 1);
    n_cmp++;
    if (credit !== 8'd100 || coin_rej !== 1'b0) begin
      n_err++; $display("FAIL max_exact: got credit=%0d rej=%b want 100 0", credit, coin_rej);
    end
    sel_valid = 1'b1; sel_id = 2'd0; vend_ready = 1'b1;
    tick();
    sel_valid = 1'b0;
    n_cmp++;
    if (vend_valid !== 1'b1 || vend_id !== 2'd0) begin
      n_err++; $display("FAIL chg_vend: got valid=%b id=%0d want 1 0", vend_valid, vend_id);
    end
    tick();
    n_cmp++;
    if (vend_valid !== 1'b0 || {A_out, B_out, C_out} !== 3'b001 || credit !== 8'd50 || busy !== 1'b1) begin
      n_err++; $display("FAIL chg_coin1: got valid=%b abc=%b credit=%0d busy=%b want 0 001 50 1",
                        vend_valid, {A_out, B_out, C_out}, credit, busy);
    end
    tick();
    n_cmp++;
    if ({A_out, B_out, C_out} !== 3'b001 || credit !== 8'd25) begin
      n_err++; $display("FAIL chg_coin2: got abc=%b credit=%0d want 001 25", {A_out, B_out, C_out}, credit);
    end
    tick();
    n_cmp++;
    if ({A_out, B_out, C_out} !== 3'b001 || credit !== 8'd0 || busy !== 1'b1) begin
      n_err++; $display("FAIL chg_coin3: got abc=%b credit=%0d busy=%b want 001 0 1",
                        {A_out, B_out, C_out}, credit, busy);
    end
    tick();
    vend_ready = 1'b0;
    n_cmp++;
    if ({A_out, B_out, C_out} !== 3'b000 || busy !== 1'b0) begin
      n_err++; $display("FAIL chg_end: got abc=%b busy=%b want 000 0", {A_out, B_out, C_out}, busy);
    end
  endtask

  task automatic test_no_credit_cancel();
    add_coin(0, 1, 0);
    add_coin(0, 1, 0);
    sel_valid = 1'b1; sel_id = 2'd2;
    tick();
    sel_valid = 1'b0;
    n_cmp++;
    if (no_credit !== 1'b1 || credit !== 8'd20 || busy !== 1'b0 || vend_valid !== 1'b0) begin
      n_err++; $display("FAIL no_credit: got noc=%b credit=%0d busy=%b valid=%b want 1 20 0 0",
                        no_credit, credit, busy, vend_valid);
    end
    tick();
    n_cmp++;
    if (no_credit !== 1'b0) begin n_err++; $display("FAIL no_credit_pulse: got %b want 0", no_credit); end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_cmp++;
    if ({A_out, B_out, C_out} !== 3'b010 || credit !== 8'd10 || busy !== 1'b1) begin
      n_err++; $display("FAIL cancel_b1: got abc=%b credit=%0d busy=%b want 010 10 1",
                        {A_out, B_out, C_out}, credit, busy);
    end
    tick();
    n_cmp++;
    if ({A_out, B_out, C_out} !== 3'b010 || credit !== 8'd0) begin
      n_err++; $display("FAIL cancel_b2: got abc=%b credit=%0d want 010 0", {A_out, B_out, C_out}, credit);
    end
    tick();
    n_cmp++;
    if ({A_out, B_out, C_out} !== 3'b000 || busy !== 1'b0) begin
      n_err++; $display("FAIL cancel_end: got abc=%b busy=%b want 000 0", {A_out, B_out, C_out}, busy);
    end
  endtask

  task automatic test_boundary();
    add_coin(0, 0, 1);
    add_coin(0, 0, 1);
    add_coin(0, 0, 1);
    add_coin(0, 1, 0);
    add_coin(1, 0, 0);
    n_cmp++;
    if (credit !== 8'd90) begin n_err++; $display("FAIL bnd_setup: got %0d want 90", credit); end
    add_coin(0, 0, 1);
    n_cmp++;
    if (coin_rej !== 1'b1 || credit !== 8'd90) begin
      n_err++; $display("FAIL bnd_over_max: got rej=%b credit=%0d want 1 90", coin_rej, credit);
    end
    add_coin(1, 1, 0);
    n_cmp++;
    if (coin_rej !== 1'b1 || credit !== 8'd90) begin
      n_err++; $display("FAIL bnd_double: got rej=%b credit=%0d want 1 90", coin_rej, credit);
    end
    add_coin(1, 0, 0);
    n_cmp++;
    if (coin_rej !== 1'b0 || credit !== 8'd95) begin
      n_err++; $display("FAIL bnd_after: got rej=%b credit=%0d want 0 95", coin_rej, credit);
    end
    do_reset();
  endtask

  task automatic test_exact_price();
    for (int i = 0; i < 4; i++) add_coin(0, 0, 1);
    sel_valid = 1'b1; sel_id = 2'd3; vend_ready = 1'b1;
    tick();
    sel_valid = 1'b0;
    n_cmp++;
    if (vend_valid !== 1'b1 || vend_id !== 2'd3) begin
      n_err++; $display("FAIL exact_vend: got valid=%b id=%0d want 1 3", vend_valid, vend_id);
    end
    tick();
    vend_ready = 1'b0;
    n_cmp++;
    if (vend_valid !== 1'b0 || credit !== 8'd0 || busy !== 1'b0 || {A_out, B_out, C_out} !== 3'b000) begin
      n_err++; $display("FAIL exact_done: got valid=%b credit=%0d busy=%b abc=%b want 0 0 0 000",
                        vend_valid, credit, busy, {A_out, B_out, C_out});
    end
  endtask

  task automatic test_reset_mid_change();
    for (int i = 0; i < 4; i++) add_coin(0, 0, 1);
    sel_valid = 1'b1; sel_id = 2'd0; vend_ready = 1'b1;
    tick();
    sel_valid = 1'b0;
    tick();
    vend_ready = 1'b0;
    n_cmp++;
    if (C_out !== 1'b1 || credit !== 8'd50) begin
      n_err++; $display("FAIL rmc_first: got C_out=%b credit=%0d want 1 50", C_out, credit);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_cmp++;
    if ({vend_valid, A_out, B_out, C_out, coin_rej, no_credit, busy} !== 7'b0 || credit !== 8'd0) begin
      n_err++; $display("FAIL rmc_reset: got outs=%b credit=%0d want 0000000 0",
                        {vend_valid, A_out, B_out, C_out, coin_rej, no_credit, busy}, credit);
    end
    tick();
    n_cmp++;
    if ({A_out, B_out, C_out} !== 3'b000 || busy !== 1'b0 || credit !== 8'd0) begin
      n_err++; $display("FAIL rmc_after: got abc=%b busy=%b credit=%0d want 000 0 0",
                        {A_out, B_out, C_out}, busy, credit);
    end
  endtask

  initial begin
    test_reset();
    test_coins();
    test_vend_delayed();
    test_change();
    test_no_credit_cancel();
    test_boundary();
    test_exact_price();
    test_reset_mid_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
